pipeline_info_serializer: RTL and testbench

Parametrised word-to-chunk serializer with an input word FIFO. The producer (pipeline debug/info capture) pushes DATA_WIDTH-bit words. The consumer (UART TX path) pulls them out CHUNK_WIDTH bits at a time, one chunk per strobe. It generalises the single-word bit-serial buffer: configurable chunk width, multi-word queueing, selectable bit order, overflow detection, flush, and zero-bubble back-to-back words.

---
 rtl/pipeline_info_serializer.sv | 151 +++++++++++++++
 tb/tb_pipeline_info_serializer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_info_serializer.sv
// Word FIFO feeding a chunk shifter: words are queued on push and
// emitted CHUNK_WIDTH bits at a time, one chunk per consumer strobe.
module pipeline_info_serializer #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned CHUNK_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter bit          MSB_FIRST   = 1'b0
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_flush,
   input  logic                          i_push,
   input  logic [DATA_WIDTH-1:0]         i_push_data,
   output logic                          o_full,
   output logic [$clog2(FIFO_DEPTH):0]   o_count,
   output logic                          o_overflow,
   input  logic                          i_chunk_done,
   output logic [CHUNK_WIDTH-1:0]        o_chunk,
   output logic                          o_chunk_valid,
   output logic                          o_word_last,
   output logic                          o_empty
);

   localparam int unsigned NCH = DATA_WIDTH / CHUNK_WIDTH;
   localparam int unsigned IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned PW  = $clog2(FIFO_DEPTH);
   localparam int unsigned CW  = PW + 1;

   typedef enum logic {
      S_IDLE,
      S_ACTIVE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic          full;
   logic          fifo_has;
   logic          last_idx;
   logic          push_ok;
   logic          pop;
   logic [IW-1:0] sel;

   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign fifo_has = (count_q != '0);
   assign last_idx = (idx_q == IW'(NCH - 1));

   always_comb begin
      state_d  = state_q;
      word_d   = word_q;
      idx_d    = idx_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      push_ok  = 1'b0;
      pop      = 1'b0;
      if (i_flush) begin
         state_d  = S_IDLE;
         word_d   = '0;
         idx_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
      end else begin
         // Full is judged on the registered count, so a same-cycle pop
         // never rescues a push at full.
         push_ok = i_push && !full;
         if (i_push && full) begin
            ovf_d = 1'b1;
         end
         unique case (state_q)
            S_IDLE: begin
               pop = fifo_has;
            end
            S_ACTIVE: begin
               if (i_chunk_done) begin
                  if (last_idx) begin
                     if (fifo_has) begin
                        pop = 1'b1;
                     end else begin
                        state_d = S_IDLE;
                        word_d  = '0;
                        idx_d   = '0;
                     end
                  end else begin
                     idx_d = idx_q + IW'(1);
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
         if (pop) begin
            state_d  = S_ACTIVE;
            word_d   = mem_q[rd_ptr_q];
            idx_d    = '0;
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q  <= S_IDLE;
         word_q   <= '0;
         idx_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         word_q   <= word_d;
         idx_q    <= idx_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset && push_ok) begin
         mem_q[wr_ptr_q] <= i_push_data;
      end
   end

   always_comb begin
      sel = MSB_FIRST ? (IW'(NCH - 1) - idx_q) : idx_q;
   end

   assign o_chunk       = word_q[sel*CHUNK_WIDTH +: CHUNK_WIDTH];
   assign o_chunk_valid = (state_q == S_ACTIVE);
   assign o_word_last   = (state_q == S_ACTIVE) && last_idx;
   assign o_full        = full;
   assign o_count       = count_q;
   assign o_overflow    = ovf_q;
   assign o_empty       = !fifo_has && (state_q == S_IDLE);

endmodule

// File: tb/tb_pipeline_info_serializer.sv
// Bench for pipeline_info_serializer: LSB-first and MSB-first instances
// share stimulus and are checked against a queue-level model.
module tb_pipeline_info_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        push = 1'b0;
   logic [31:0] pdata = '0;
   logic        done = 1'b0;

   logic        a_full, a_ovf, a_valid, a_last, a_empty;
   logic [2:0]  a_count;
   logic [7:0]  a_chunk;
   logic        b_full, b_ovf, b_valid, b_last, b_empty;
   logic [2:0]  b_count;
   logic [7:0]  b_chunk;

   int vecs = 0;
   int errs = 0;

   // Model state: word queue, word in progress and its chunk index.
   logic [31:0] mq[$];
   logic [31:0] mword;
   int          midx;
   bit          mact;
   bit          movf;

   always #5 clk = ~clk;

   pipeline_info_serializer u_lsb (
      .i_clk(clk), .i_reset(rst_n), .i_flush(flush),
      .i_push(push), .i_push_data(pdata),
      .o_full(a_full), .o_count(a_count), .o_overflow(a_ovf),
      .i_chunk_done(done), .o_chunk(a_chunk),
      .o_chunk_valid(a_valid), .o_word_last(a_last),
      .o_empty(a_empty)
   );

   pipeline_info_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .i_clk(clk), .i_reset(rst_n), .i_flush(flush),
      .i_push(push), .i_push_data(pdata),
      .o_full(b_full), .o_count(b_count), .o_overflow(b_ovf),
      .i_chunk_done(done), .o_chunk(b_chunk),
      .o_chunk_valid(b_valid), .o_word_last(b_last),
      .o_empty(b_empty)
   );

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mchunk(bit msb);
      int k;
      k = msb ? 3 - midx : midx;
      return mact ? 8'((mword >> (8 * k)) & 32'hFF) : 8'h00;
   endfunction

   task automatic model_step();
      bit acc;
      bit pop;
      if (!rst_n || flush) begin
         mq.delete();
         mword = '0;
         midx = 0;
         mact = 0;
         movf = 0;
      end else begin
         acc = push && (mq.size() < 4);
         if (push && !acc) movf = 1;
         pop = 0;
         if (!mact) begin
            pop = (mq.size() > 0);
         end else if (done) begin
            if (midx == 3) begin
               if (mq.size() > 0) pop = 1;
               else begin
                  mact = 0;
                  mword = '0;
                  midx = 0;
               end
            end else begin
               midx++;
            end
         end
         if (pop) begin
            mword = mq.pop_front();
            midx = 0;
            mact = 1;
         end
         if (acc) mq.push_back(pdata);
      end
   endtask

   task automatic compare_all();
      int n;
      n = mq.size();
      chk("lsb_chunk", 32'(a_chunk), 32'(mchunk(0)));
      chk("msb_chunk", 32'(b_chunk), 32'(mchunk(1)));
      chk("lsb_valid", 32'(a_valid), 32'(mact));
      chk("msb_valid", 32'(b_valid), 32'(mact));
      chk("lsb_last", 32'(a_last), 32'(mact && midx == 3));
      chk("msb_last", 32'(b_last), 32'(mact && midx == 3));
      chk("lsb_count", 32'(a_count), 32'(n));
      chk("msb_count", 32'(b_count), 32'(n));
      chk("lsb_full", 32'(a_full), 32'(n == 4));
      chk("msb_full", 32'(b_full), 32'(n == 4));
      chk("lsb_empty", 32'(a_empty), 32'(n == 0 && !mact));
      chk("msb_empty", 32'(b_empty), 32'(n == 0 && !mact));
      chk("lsb_ovf", 32'(a_ovf), 32'(movf));
      chk("msb_ovf", 32'(b_ovf), 32'(movf));
   endtask

   task automatic cyc(bit r, bit f, bit p, logic [31:0] d, bit dn);
      @(negedge clk);
      rst_n = r;
      flush = f;
      push = p;
      pdata = d;
      done = dn;
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic idle(bit dn);
      cyc(1, 0, 0, 32'h0, dn);
   endtask

   task automatic put(logic [31:0] d);
      cyc(1, 0, 1, d, 0);
   endtask

   logic [7:0] seq_a [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
   logic [7:0] seq_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

   initial begin
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_valid", 32'(a_valid), 32'd0);
      chk("rst_count", 32'(a_count), 32'd0);

      put(32'hA1B2C3D4);
      chk("lat_valid0", 32'(a_valid), 32'd0);
      chk("lat_count1", 32'(a_count), 32'd1);
      idle(0);
      chk("lat_valid1", 32'(a_valid), 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("seq_lsb", 32'(a_chunk), 32'(seq_a[i]));
         chk("seq_msb", 32'(b_chunk), 32'(seq_b[i]));
         chk("seq_last", 32'(a_last), 32'(i == 3));
         idle(1);
      end
      chk("seq_idle", 32'(a_valid), 32'd0);
      chk("seq_empty", 32'(a_empty), 32'd1);

      put(32'h11111111);
      put(32'h22222222);
      for (int i = 0; i < 8; i++) begin
         chk("b2b_valid", 32'(a_valid), 32'd1);
         chk("b2b_chunk", 32'(a_chunk), (i < 4) ? 32'h11 : 32'h22);
         idle(1);
      end
      chk("b2b_end", 32'(a_valid), 32'd0);

      for (int j = 1; j <= 6; j++) put(32'hC0DE0000 | 32'(j));
      chk("ovf_count", 32'(a_count), 32'd4);
      chk("ovf_full", 32'(a_full), 32'd1);
      chk("ovf_flag", 32'(a_ovf), 32'd1);
      for (int j = 1; j <= 5; j++) begin
         chk("drain_word", 32'(a_chunk), 32'(j));
         for (int c = 0; c < 4; c++) idle(1);
      end
      chk("drain_end", 32'(a_valid), 32'd0);
      chk("ovf_sticky", 32'(a_ovf), 32'd1);

      put(32'hA1B2C3D4);
      idle(0);
      idle(1);
      idle(1);
      chk("mid_chunk", 32'(a_chunk), 32'hB2);
      cyc(0, 0, 0, 0, 0);
      chk("mrst_valid", 32'(a_valid), 32'd0);
      chk("mrst_count", 32'(a_count), 32'd0);
      chk("mrst_ovf", 32'(a_ovf), 32'd0);
      chk("mrst_empty", 32'(a_empty), 32'd1);
      put(32'h55667788);
      idle(0);
      chk("mrst_first", 32'(a_chunk), 32'h88);
      for (int c = 0; c < 4; c++) idle(1);

      put(32'hAAAA0001);
      put(32'hAAAA0002);
      put(32'hAAAA0003);
      chk("fl_pre", 32'(a_count), 32'd2);
      cyc(1, 1, 1, 32'h12345678, 0);
      chk("fl_count", 32'(a_count), 32'd0);
      chk("fl_empty", 32'(a_empty), 32'd1);
      for (int c = 0; c < 8; c++) begin
         idle(1);
         chk("fl_novalid", 32'(a_valid), 32'd0);
      end

      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 99) == 0),
             ($urandom_range(0, 99) < 45),
             $urandom,
             ($urandom_range(0, 99) < 60));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
